fifo_rr_share_ctrl: RTL and testbench

- Controller that shares one 256x60 FIFO (registered-read dual-port RAM inside) between NSRC=4 producer streams.
- Write side: round-robin arbitration; the granted source's 58-bit payload is tagged with its 2-bit source ID to form a 60-bit FIFO word.
- Read side: sequences FIFO pops, absorbs the 1-cycle RAM read latency, and presents a valid/ready stream with a 2-entry output buffer.
- Also owns FIFO flush (clr) and occupancy tracking; sits between the producer engines and the downstream consumer.

---
 rtl/fifo_rr_share_ctrl_if.sv | 42 ++++
 rtl/fifo_rr_share_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fifo_rr_share_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_share_ctrl_if.sv
// fifo_rr_share_ctrl_if: producer, consumer and FIFO-side signals
// of the shared-FIFO controller; the controller uses the slave view.
interface fifo_rr_share_ctrl_if #(
    parameter int DW   = 58,
    parameter int NSRC = 4,
    parameter int AW   = 8
);
    logic              flush;
    logic [NSRC-1:0]   src_en;
    logic [NSRC-1:0]   src_valid;
    logic [NSRC*DW-1:0] src_data;
    logic [NSRC-1:0]   src_ready;
    logic              m_valid;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_src;
    logic              m_ready;
    logic [DW+1:0]     fifo_din;
    logic              fifo_we;
    logic              fifo_re;
    logic              fifo_clr;
    logic [DW+1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       occupancy;
    logic              busy;

    modport master (
        output flush, src_en, src_valid, src_data,
        output m_ready, fifo_dout, fifo_full, fifo_empty,
        input  src_ready, m_valid, m_data, m_src,
        input  fifo_din, fifo_we, fifo_re, fifo_clr,
        input  occupancy, busy
    );

    modport slave (
        input  flush, src_en, src_valid, src_data,
        input  m_ready, fifo_dout, fifo_full, fifo_empty,
        output src_ready, m_valid, m_data, m_src,
        output fifo_din, fifo_we, fifo_re, fifo_clr,
        output occupancy, busy
    );
endinterface

// File: rtl/fifo_rr_share_ctrl.sv
// fifo_rr_share_ctrl: four producers share one registered-read FIFO
// through round-robin writes, tagged words and a 2-entry output queue.
module fifo_rr_share_ctrl #(
    parameter int DW   = 58,
    parameter int NSRC = 4,
    parameter int AW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_rr_share_ctrl_if.slave  bus
);
    localparam int FW = DW + 2;
    localparam logic [AW:0] OCC_ONE = 1;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        RECOVER
    } state_t;

    state_t          state;
    logic            clr_q;
    logic [1:0]      rr_ptr;
    logic            inflight;
    logic [1:0]      buf_cnt;
    logic [FW-1:0]   buf0;
    logic [FW-1:0]   buf1;
    logic [AW:0]     occ;

    logic            run;
    logic            wipe;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] grant;
    logic [1:0]      gidx;
    logic [1:0]      idx;
    logic            found;
    logic            we;
    logic            re;
    logic            pop;
    logic            cap;
    logic            mv;

    // Handshakes are held off while reset is asserted.
    assign run  = rst_n && (state == RUN);
    assign wipe = (state == FLUSH);
    assign cand = bus.src_valid & bus.src_en;

    // Round-robin pick starting one past the last winner.
    always_comb begin
        grant = '0;
        gidx  = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
        if (run && !bus.flush && !bus.fifo_full) begin
            for (int k = 1; k <= NSRC; k++) begin
                idx = rr_ptr + 2'(k);
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    gidx  = idx;
                end
            end
            if (found) begin
                grant[gidx] = 1'b1;
            end
        end
    end

    assign we  = |grant;
    assign mv  = run && (buf_cnt != 2'd0);
    assign pop = mv && bus.m_ready;
    assign cap = inflight;

    // Pop only if the word can land in the queue after
    // accounting for the read still in flight.
    assign re = run && !bus.fifo_empty &&
                (({1'b0, buf_cnt} + {2'b0, inflight}) <
                 (3'd2 + {2'b0, pop}));

    // Mode sequencing; fifo_clr is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            clr_q <= 1'b0;
        end else if (bus.flush) begin
            state <= FLUSH;
            clr_q <= 1'b1;
        end else begin
            clr_q <= 1'b0;
            unique case (state)
                RUN:     state <= RUN;
                FLUSH:   state <= RECOVER;
                RECOVER: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Remember the last winner for the next search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd3;
        end else if (we) begin
            rr_ptr <= gidx;
        end
    end

    // Track FIFO occupancy and the outstanding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
        end else if (wipe) begin
            occ      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= re;
            if (we && !re) begin
                occ <= occ + OCC_ONE;
            end else if (re && !we) begin
                occ <= occ - OCC_ONE;
            end
        end
    end

    // In-order 2-entry queue; capture and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else if (wipe) begin
            buf_cnt <= 2'd0;
        end else begin
            unique case ({cap, pop})
                2'b11: begin
                    if (buf_cnt == 2'd2) begin
                        buf0 <= buf1;
                        buf1 <= bus.fifo_dout;
                    end else begin
                        buf0 <= bus.fifo_dout;
                    end
                end
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf0 <= bus.fifo_dout;
                    end else begin
                        buf1 <= bus.fifo_dout;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.src_ready = grant;
    assign bus.fifo_we   = we;
    assign bus.fifo_din  = {gidx, bus.src_data[gidx*DW +: DW]};
    assign bus.fifo_re   = re;
    assign bus.fifo_clr  = clr_q;
    assign bus.m_valid   = mv;
    assign bus.m_src     = buf0[FW-1 -: 2];
    assign bus.m_data    = buf0[DW-1:0];
    assign bus.occupancy = occ;
    assign bus.busy      = (occ != '0) || (buf_cnt != 2'd0) || inflight;

    a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(cap && !pop && (buf_cnt == 2'd2)));

    a_no_we_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(we && bus.fifo_full));

    a_no_re_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(re && bus.fifo_empty));
endmodule

// File: tb/tb_fifo_rr_share_ctrl.sv
// tb_fifo_rr_share_ctrl: directed bench with a behavioural
// 256x60 registered-read FIFO behind the controller.
module tb_fifo_rr_share_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_rr_share_ctrl_if #(.DW(58), .NSRC(4), .AW(8)) bus ();

    fifo_rr_share_ctrl #(.DW(58), .NSRC(4), .AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural FIFO: registered read, synchronous clear.
    logic [59:0] mem [256];
    logic [7:0]  wp;
    logic [7:0]  rp;
    logic [8:0]  fcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            fcnt <= '0;
            bus.fifo_dout <= '0;
        end else if (bus.fifo_clr) begin
            wp <= '0;
            rp <= '0;
            fcnt <= '0;
        end else begin
            if (bus.fifo_we) begin
                mem[wp] <= bus.fifo_din;
                wp <= wp + 8'd1;
            end
            if (bus.fifo_re) begin
                bus.fifo_dout <= mem[rp];
                rp <= rp + 8'd1;
            end
            fcnt <= fcnt + 9'(bus.fifo_we) - 9'(bus.fifo_re);
        end
    end

    assign bus.fifo_full  = (fcnt == 9'd256);
    assign bus.fifo_empty = (fcnt == 9'd0);

    logic [59:0] wr_q[$];
    logic [59:0] rx_q[$];
    int re_empty_bad = 0;
    int we_full_bad = 0;
    int occ_bad = 0;

    // Log both handshakes and watch flag consistency.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fifo_we) wr_q.push_back(bus.fifo_din);
            if (bus.m_valid && bus.m_ready)
                rx_q.push_back({bus.m_src, bus.m_data});
            if (bus.fifo_re && bus.fifo_empty) re_empty_bad++;
            if (bus.fifo_we && bus.fifo_full) we_full_bad++;
            if (bus.occupancy != fcnt) occ_bad++;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [57:0] v);
        bus.src_data[i*58 +: 58] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.src_valid = '0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [63:0] outs();
        return {51'd0, bus.src_ready, bus.m_valid, bus.fifo_we,
                bus.fifo_re, bus.fifo_clr, bus.busy,
                bus.m_src, bus.occupancy == 9'd0 ? 1'b0 : 1'b1};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int bw;
        int br;
        int bad;
        int sent;
        int peak;
        int popped;
        logic [59:0] w;
        int seq2[6];
        seq2 = '{0, 1, 3, 0, 1, 3};

        bus.flush = 1'b0;
        bus.src_en = 4'hF;
        bus.src_valid = 4'hF;
        bus.src_data = '0;
        bus.m_ready = 1'b0;

        // Reset: every output low even with requests pending.
        @(negedge clk);
        check("rst_outs", outs(), 64'd0);
        check("rst_occ", 64'(bus.occupancy), 64'd0);
        check("rst_mdata", 64'(bus.m_data), 64'd0);
        do_reset();

        // T1: single write from src0 and its latency.
        set_data(0, 58'h155);
        bus.src_valid = 4'b0001;
        @(negedge clk);
        check("t1_ready", 64'(bus.src_ready), 64'h1);
        check("t1_we", 64'(bus.fifo_we), 64'd1);
        check("t1_din", 64'(bus.fifo_din), {6'd0, 2'd0, 58'h155});
        tick();
        bus.src_valid = '0;
        @(negedge clk);
        check("t1_re", 64'(bus.fifo_re), 64'd1);
        tick();
        @(negedge clk);
        check("t1_mv_early", 64'(bus.m_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t1_mv", 64'(bus.m_valid), 64'd1);
        check("t1_mdata", 64'(bus.m_data), 64'h155);
        check("t1_msrc", 64'(bus.m_src), 64'd0);
        tick();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("t1_mv_done", 64'(bus.m_valid), 64'd0);
        check("t1_busy", 64'(bus.busy), 64'd0);

        // T2: round-robin with all sources, then src2 disabled.
        do_reset();
        bw = wr_q.size();
        br = rx_q.size();
        for (int i = 0; i < 4; i++) set_data(i, 58'h100 + 58'(i));
        bus.src_en = 4'hF;
        bus.src_valid = 4'hF;
        bus.m_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            tick();
        end
        bus.src_en = 4'b1011;
        repeat (6) begin
            @(negedge clk);
            tick();
        end
        bus.src_valid = '0;
        bus.src_en = 4'hF;
        check("t2_nwr", 64'(wr_q.size() - bw), 64'd14);
        for (int k = 0; k < 8; k++) begin
            w = (wr_q.size() > bw + k) ? wr_q[bw+k] : '1;
            check($sformatf("t2_g%0d", k), 64'(w[59:58]), 64'(k % 4));
        end
        for (int k = 0; k < 6; k++) begin
            w = (wr_q.size() > bw + 8 + k) ? wr_q[bw+8+k] : '1;
            check($sformatf("t2_m%0d", k), 64'(w[59:58]), 64'(seq2[k]));
        end
        for (int c = 0; c < 50 && rx_q.size() - br < 14; c++) tick();
        check("t2_nrx", 64'(rx_q.size() - br), 64'd14);
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            if (rx_q.size() > br + k && wr_q.size() > bw + k) begin
                if (rx_q[br+k] !== wr_q[bw+k]) bad++;
            end
        end
        check("t2_order", 64'(bad), 64'd0);

        // T3: fill to full with the consumer stalled, then drain.
        do_reset();
        br = rx_q.size();
        sent = 0;
        peak = 0;
        bus.src_valid = 4'b0010;
        for (int c = 0; c < 300; c++) begin
            set_data(1, 58'(sent));
            @(negedge clk);
            if (bus.src_ready[1]) sent++;
            if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
            tick();
        end
        @(negedge clk);
        check("t3_sent", 64'(sent), 64'd258);
        check("t3_full", 64'(bus.fifo_full), 64'd1);
        check("t3_ready", 64'(bus.src_ready), 64'd0);
        check("t3_occ", 64'(bus.occupancy), 64'd256);
        check("t3_peak", 64'(peak), 64'd256);
        check("t3_mv", 64'(bus.m_valid), 64'd1);
        tick();
        bus.src_valid = '0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 400 && rx_q.size() - br < 258; c++) tick();
        check("t3_nrx", 64'(rx_q.size() - br), 64'd258);
        bad = 0;
        for (int k = 0; k < 258; k++) begin
            if (rx_q.size() > br + k) begin
                if (rx_q[br+k] !== {2'd1, 58'(k)}) bad++;
            end
        end
        check("t3_order", 64'(bad), 64'd0);
        tick();
        @(negedge clk);
        check("t3_idle", 64'(bus.busy), 64'd0);

        // T4: consumer toggling ready; busy holds until last pop.
        do_reset();
        br = rx_q.size();
        bus.src_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            set_data(2, 58'h2A0 + 58'(k));
            tick();
        end
        bus.src_valid = '0;
        popped = 0;
        bad = 0;
        for (int c = 0; c < 40 && popped < 3; c++) begin
            bus.m_ready = ((c % 2) == 1);
            @(negedge clk);
            if (!bus.busy) bad++;
            if (bus.m_valid && bus.m_ready) popped++;
            tick();
        end
        bus.m_ready = 1'b0;
        check("t4_pops", 64'(popped), 64'd3);
        check("t4_busy_held", 64'(bad), 64'd0);
        @(negedge clk);
        check("t4_busy_off", 64'(bus.busy), 64'd0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (rx_q.size() > br + k) begin
                if (rx_q[br+k] !== {2'd2, 58'h2A0 + 58'(k)}) bad++;
            end else begin
                bad++;
            end
        end
        check("t4_order", 64'(bad), 64'd0);

        // T5: flush with 10 words queued, racing a source accept.
        tick();
        do_reset();
        bus.src_valid = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            set_data(3, 58'h300 + 58'(k));
            tick();
        end
        bus.src_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        check("t5_occ", 64'(bus.occupancy), 64'd8);
        check("t5_mv", 64'(bus.m_valid), 64'd1);
        tick();
        br = rx_q.size();
        set_data(3, 58'h3FF);
        bus.flush = 1'b1;
        bus.src_valid = 4'b1000;
        @(negedge clk);
        check("t5_fl_ready", 64'(bus.src_ready), 64'd0);
        check("t5_fl_we", 64'(bus.fifo_we), 64'd0);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        check("t5_clr", 64'(bus.fifo_clr), 64'd1);
        check("t5_clr_mv", 64'(bus.m_valid), 64'd0);
        check("t5_clr_rdy", 64'(bus.src_ready), 64'd0);
        check("t5_clr_re", 64'(bus.fifo_re), 64'd0);
        tick();
        @(negedge clk);
        check("t5_rec_clr", 64'(bus.fifo_clr), 64'd0);
        check("t5_rec_occ", 64'(bus.occupancy), 64'd0);
        check("t5_rec_rdy", 64'(bus.src_ready), 64'd0);
        check("t5_rec_busy", 64'(bus.busy), 64'd0);
        tick();
        @(negedge clk);
        check("t5_run_rdy", 64'(bus.src_ready), 64'h8);
        tick();
        bus.src_valid = '0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20 && rx_q.size() - br < 1; c++) tick();
        repeat (3) tick();
        check("t5_nrx", 64'(rx_q.size() - br), 64'd1);
        w = (rx_q.size() > br) ? rx_q[br] : '1;
        check("t5_word", 64'(w), {6'd0, 2'd3, 58'h3FF});

        // T6: asynchronous reset in the middle of a stream.
        do_reset();
        bus.src_valid = 4'b0001;
        repeat (52) tick();
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("t6_occ", 64'(bus.occupancy), 64'd50);
        check("t6_re", 64'(bus.fifo_re), 64'd1);
        tick();
        check("t6_occ_hold", 64'(bus.occupancy), 64'd50);
        bus.src_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", outs(), 64'd0);
        check("t6_rst_occ", 64'(bus.occupancy), 64'd0);
        check("t6_rst_mdata", 64'(bus.m_data), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_first_rdy", 64'(bus.src_ready), 64'h1);
        check("t6_first_tag", 64'(bus.fifo_din[59:58]), 64'd0);
        tick();
        bus.src_valid = '0;
        repeat (2) tick();

        check("mon_re_empty", 64'(re_empty_bad), 64'd0);
        check("mon_we_full", 64'(we_full_bad), 64'd0);
        check("mon_occ_track", 64'(occ_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
